// File: rtl/tremolo_lfo_mod.sv
// Tremolo: scales a streaming signed sample by a gain derived from a triangle LFO,
// and paces the LFO generator with one step pulse every `rate` accepted samples.
module tremolo_lfo_mod #(
    parameter int DW     = 24,
    parameter int N      = 8,
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [RATE_W-1:0] rate,
    input  logic [N-1:0]      depth,
    output logic              lfo_nxt,
    input  logic [N-1:0]      lfo_wav,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data
);

    logic              v1;
    logic [DW-1:0]     d1;
    logic [N-1:0]      wav1;
    logic [N-1:0]      dep1;
    logic              en1;
    logic [RATE_W-1:0] cnt;

    logic              adv;
    logic              accept;
    logic [2*N-1:0]    att_full;
    logic [N-1:0]      att;
    logic [N-1:0]      gain;
    logic signed [DW+N-1:0] d_ext;
    logic signed [DW+N-1:0] g_ext;
    logic signed [DW+N-1:0] prod;
    logic [DW-1:0]     result;
    logic              unused_bits;

    assign adv     = ~m_valid | m_ready;
    assign s_ready = adv | ~v1;
    assign accept  = s_valid & s_ready;

    // Stage 1: capture sample together with the LFO/depth/enable seen at accept time
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (accept) begin
            v1 <= 1'b1;
        end else if (adv) begin
            v1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            d1   <= s_data;
            wav1 <= lfo_wav;
            dep1 <= depth;
            en1  <= en;
        end
    end

    // |d| * gain stays below 2^(DW+N-1), so DW+N signed bits hold the product exactly
    assign att_full = {{N{1'b0}}, dep1} * {{N{1'b0}}, wav1};
    assign att      = att_full[2*N-1:N];
    assign gain     = {N{1'b1}} - att;
    assign d_ext    = {{N{d1[DW-1]}}, d1};
    assign g_ext    = {{DW{1'b0}}, gain};
    assign prod     = d_ext * g_ext;
    assign result   = en1 ? prod[DW+N-1:N] : d1;
    assign unused_bits = ^{att_full[N-1:0], prod[N-1:0]};

    // Stage 2: output register, holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (adv) begin
            m_valid <= v1;
            if (v1) begin
                m_data <= result;
            end
        end
    end

    // Rate divider: >= compare lets a lowered rate wrap on the very next accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            lfo_nxt <= 1'b0;
        end else if (!en || rate == '0) begin
            cnt     <= '0;
            lfo_nxt <= 1'b0;
        end else if (accept) begin
            if (cnt >= rate - RATE_W'(1)) begin
                cnt     <= '0;
                lfo_nxt <= 1'b1;
            end else begin
                cnt     <= cnt + RATE_W'(1);
                lfo_nxt <= 1'b0;
            end
        end else begin
            lfo_nxt <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tremolo_lfo_mod.sv
// Bench for tremolo_lfo_mod: directed cases plus randomized traffic checked every cycle
// against a transaction-level model (queue of expected outputs, accept counter for LFO steps).
module tb_tremolo_lfo_mod;
    localparam int DW = 24;
    localparam int N  = 8;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [RW-1:0] rate = '0;
    logic [N-1:0]  depth = '0;
    logic [N-1:0]  lfo_wav = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          m_ready = 1'b1;
    logic          lfo_nxt;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;

    int errors = 0;
    int checks = 0;

    tremolo_lfo_mod #(.DW(DW), .N(N), .RATE_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rate(rate), .depth(depth),
        .lfo_nxt(lfo_nxt), .lfo_wav(lfo_wav),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Tremolo rule in plain integer arithmetic
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [N-1:0] w,
                                            input logic [N-1:0] dp, input logic e);
        longint s, g, p;
        if (!e) return d;
        s = longint'($signed(d));
        g = 255 - ((longint'(dp) * longint'(w)) / 256);
        p = s * g;
        return DW'(p >>> 8);
    endfunction

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] out_log[$];
    int            cyc = 0;
    int            acc_total = 0;
    int            exp_cnt = 0;
    bit            exp_nxt = 0;
    bit            armed = 0;
    int            pulse_cnt = 0;

    // Monitor: check at negedge, advance the model at posedge
    initial begin
        bit acc_f, out_f, exp_valid;
        forever begin
            @(negedge clk);
            acc_f = rst_n && s_valid && s_ready;
            out_f = rst_n && m_valid && m_ready;
            if (lfo_nxt) pulse_cnt++;
            if (armed && rst_n) begin
                exp_valid = (q.size() > 0) && ((cyc - q[0].t + 1) >= 2);
                chk("mon_m_valid", m_valid, exp_valid);
                if (exp_valid) chk("mon_m_data", m_data, q[0].d);
                chk("mon_s_ready", s_ready, !(q.size() == 2 && !m_ready));
                chk("mon_lfo_nxt", lfo_nxt, exp_nxt);
            end
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                q.delete();
                exp_cnt = 0;
                exp_nxt = 0;
                armed   = 1;
            end else begin
                if (out_f) begin
                    out_log.push_back(q[0].d);
                    void'(q.pop_front());
                end
                if (acc_f) begin
                    q.push_back('{d: model(s_data, lfo_wav, depth, en), t: cyc});
                    acc_total++;
                end
                if (!en || rate == 0) begin
                    exp_cnt = 0;
                    exp_nxt = 0;
                end else if (acc_f) begin
                    exp_cnt++;
                    exp_nxt = (exp_cnt >= int'(rate));
                    if (exp_nxt) exp_cnt = 0;
                end else begin
                    exp_nxt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_chk(input logic [DW-1:0] d, input logic [N-1:0] w, input logic [N-1:0] dp,
                            input logic [DW-1:0] exp_v, input string nm);
        s_data = d; lfo_wav = w; depth = dp; en = 1'b1; m_ready = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        lfo_wav = ~w;
        chk({nm, "_lat1_valid"}, m_valid, 1'b0);
        tick();
        chk({nm, "_valid"}, m_valid, 1'b1);
        chk({nm, "_data"}, m_data, exp_v);
        tick();
    endtask

    task automatic push(input logic [DW-1:0] d);
        bit a;
        int n;
        s_valid = 1'b1;
        s_data  = d;
        a = 0;
        n = 0;
        while (!a && n < 50) begin
            @(negedge clk);
            a = s_ready;
            tick();
            n++;
        end
        if (!a) chk("push_timeout", 1'b0, 1'b1);
        s_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, c, n;
        bit acc, sawdrop;

        // Pin the model itself with hand-computed values
        chk("pin_T1", model(24'h100000, 8'd200, 8'd0, 1'b1), 24'h0FF000);
        chk("pin_T2", model(24'h100000, 8'd255, 8'd255, 1'b1), 24'h001000);
        chk("pin_T3", model(24'hFFFF00, 8'd128, 8'd128, 1'b1), 24'hFFFF41);
        chk("pin_bypass", model(24'h812345, 8'd77, 8'd200, 1'b0), 24'h812345);

        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 24'h0);
        chk("rst_lfo_nxt", lfo_nxt, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);

        send_chk(24'h100000, 8'd200, 8'd0, 24'h0FF000, "T1");
        send_chk(24'h100000, 8'd255, 8'd255, 24'h001000, "T2");
        send_chk(24'hFFFF00, 8'd128, 8'd128, 24'hFFFF41, "T3");

        // T4: LFO step pacing
        rate = 16'd3; en = 1'b1; m_ready = 1'b1; depth = 8'd100;
        tick();
        pulse_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1; s_data = 24'($urandom); lfo_wav = 8'($urandom);
            tick();
        end
        s_valid = 1'b0;
        tick(); tick();
        chk("T4_pulses_rate3", pulse_cnt, 3);
        rate = 16'd0;
        pulse_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            s_valid = 1'b1; s_data = 24'($urandom);
            tick();
        end
        s_valid = 1'b0;
        tick(); tick();
        chk("T4_pulses_rate0", pulse_cnt, 0);

        // T5: backpressure with a ramp
        depth = 8'd0; en = 1'b1;
        out_log.delete();
        idx = 1; c = 0; sawdrop = 0;
        while (idx <= 10 && c < 100) begin
            s_valid = 1'b1; s_data = DW'(idx); m_ready = !(c >= 3 && c <= 7);
            @(negedge clk);
            acc = s_ready;
            if (!s_ready) sawdrop = 1;
            tick();
            if (acc) idx++;
            c++;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (6) tick();
        chk("T5_s_ready_dropped", sawdrop, 1'b1);
        chk("T5_out_count", out_log.size(), 10);
        for (int k = 0; k < 10 && k < out_log.size(); k++)
            chk($sformatf("T5_out%0d", k), out_log[k], DW'(k));

        // T6: bypass
        en = 1'b0; rate = 16'd2; depth = 8'd255; lfo_wav = 8'd255;
        pulse_cnt = 0;
        out_log.delete();
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1; s_data = 24'h400000 + DW'(i);
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        chk("T6_bypass_pulses", pulse_cnt, 0);
        chk("T6_bypass_first", out_log.size() > 0 ? out_log[0] : 24'hx, 24'h400000);

        // T6: reset mid-stream, with both stages full and the divider part-way
        en = 1'b1; rate = 16'd3; depth = 8'd0; m_ready = 1'b0;
        push(24'h000111);
        push(24'h000222);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        chk("T6_rst_m_valid", m_valid, 1'b0);
        pulse_cnt = 0;
        out_log.delete();
        push(24'h123456);
        n = 0;
        while (out_log.size() == 0 && n < 10) begin tick(); n++; end
        chk("T6_first_after_rst", out_log.size() > 0 ? out_log[0] : 24'hx, 24'h122221);
        chk("T6_no_pulse_after_1", pulse_cnt, 0);
        push(24'h000001);
        push(24'h000002);
        tick(); tick();
        chk("T6_pulse_after_3", pulse_cnt, 1);

        // Randomized traffic
        rate = 16'd2;
        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 99) == 0) rate = RW'($urandom_range(0, 4));
            en      = ($urandom_range(0, 9) != 0);
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = 24'($urandom);
            lfo_wav = 8'($urandom);
            case ($urandom_range(0, 3))
                0: depth = 8'd0;
                1: depth = 8'd255;
                default: depth = 8'($urandom);
            endcase
            m_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        repeat (5) tick();
        chk("rand_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
